voice_allocator: RTL and testbench

Polyphonic voice scheduler between the note-event source (Nios II PIO / USB-MIDI path) and the pool of `Voice` instances. Accepts note-on/note-off events over a valid/ready handshake, assigns each note-on to a free voice or steals the oldest, and drives each voice's `key_on`, frequency index and amplitude. On re-trigger or steal it forces a timed `key_on` gap, so the sample-rate ADSR sees a clean release/attack edge. Replaces the direct per-voice software register writes.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/gap_timer.sv | 33 +++
 rtl/voice_allocator.sv | 169 ++++++++++++++++
 tb/tb_voice_allocator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, state and voice types for the voice allocator
package synth_pkg;
   localparam int NOTE_W = 8;
   localparam int AMP_W  = 16;
   localparam int AGE_W  = 8;
   localparam int VEL_W  = 7;

   typedef enum logic [1:0] {IDLE, SCAN, APPLY, GAP} alloc_state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [AMP_W-1:0]  amp;
      logic [AGE_W-1:0]  age;
   } voice_t;

   // Replicating the velocity bits spans full scale: 127 -> 0xFFFF, 0 -> 0x0000.
   function automatic logic [AMP_W-1:0] vel_to_amp(input logic [VEL_W-1:0] vel);
      return {vel, vel, vel[VEL_W-1 -: 2]};
   endfunction
endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - loadable down-counter timing the key_on re-trigger gap
module gap_timer #(
   parameter int unsigned LOAD = 2048
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   output logic done_o
);
   localparam int CW = $clog2(LOAD + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = CW'(LOAD);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags the last loaded cycle so the caller leaves exactly LOAD cycles after start.
   assign done_o = (cnt_q == CW'(1));
endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-event to voice scheduler with voice stealing and re-trigger gap
module voice_allocator
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned RETRIG_GAP = 2048
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         ev_valid,
   output logic                         ev_ready,
   input  logic                         ev_on,
   input  logic [NOTE_W-1:0]            ev_note,
   input  logic [VEL_W-1:0]             ev_vel,
   output logic [NUM_VOICES-1:0]        key_on,
   output logic [NUM_VOICES*NOTE_W-1:0] note_out,
   output logic [NUM_VOICES*AMP_W-1:0]  amp_out,
   output logic                         busy
);
   localparam int               IDX_W    = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   alloc_state_t          state_q;
   voice_t                voices_q [NUM_VOICES];
   logic [NUM_VOICES-1:0] key_on_q;
   logic                  ev_ready_q, busy_q;
   logic                  ev_on_q;
   logic [NOTE_W-1:0]     ev_note_q;
   logic [VEL_W-1:0]      ev_vel_q;
   logic [IDX_W-1:0]      idx_q, tgt_q;
   logic                  match_vld_q, free_vld_q, old_vld_q;
   logic [IDX_W-1:0]      match_idx_q, free_idx_q, old_idx_q;
   logic [AGE_W-1:0]      old_age_q;

   logic [IDX_W-1:0]      tgt_d;
   logic                  retrig_d;
   logic                  gap_start, gap_done;

   // Target priority: same note, then a free voice, then steal the oldest.
   always_comb begin
      tgt_d    = old_idx_q;
      retrig_d = 1'b1;
      if (match_vld_q) begin
         tgt_d = match_idx_q;
      end else if (free_vld_q) begin
         tgt_d    = free_idx_q;
         retrig_d = 1'b0;
      end
   end

   assign gap_start = (state_q == APPLY) && ev_on_q && retrig_d;

   gap_timer #(.LOAD(RETRIG_GAP)) u_gap_timer (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .start_i(gap_start),
      .done_o (gap_done)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         key_on_q    <= '0;
         ev_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         ev_on_q     <= 1'b0;
         ev_note_q   <= '0;
         ev_vel_q    <= '0;
         idx_q       <= '0;
         tgt_q       <= '0;
         match_vld_q <= 1'b0;
         free_vld_q  <= 1'b0;
         old_vld_q   <= 1'b0;
         match_idx_q <= '0;
         free_idx_q  <= '0;
         old_idx_q   <= '0;
         old_age_q   <= '0;
         for (int i = 0; i < NUM_VOICES; i++) voices_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ev_valid) begin
                  ev_on_q     <= ev_on && (ev_vel != '0);
                  ev_note_q   <= ev_note;
                  ev_vel_q    <= ev_vel;
                  match_vld_q <= 1'b0;
                  free_vld_q  <= 1'b0;
                  old_vld_q   <= 1'b0;
                  idx_q       <= '0;
                  ev_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               if (key_on_q[idx_q]) begin
                  if (!match_vld_q && voices_q[idx_q].note == ev_note_q) begin
                     match_vld_q <= 1'b1;
                     match_idx_q <= idx_q;
                  end
                  if (!old_vld_q || voices_q[idx_q].age > old_age_q) begin
                     old_vld_q <= 1'b1;
                     old_idx_q <= idx_q;
                     old_age_q <= voices_q[idx_q].age;
                  end
               end else if (!free_vld_q) begin
                  free_vld_q <= 1'b1;
                  free_idx_q <= idx_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= APPLY;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            APPLY: begin
               if (ev_on_q) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (IDX_W'(i) == tgt_d) begin
                        voices_q[i].note <= ev_note_q;
                        voices_q[i].amp  <= vel_to_amp(ev_vel_q);
                        voices_q[i].age  <= '0;
                     end else if (key_on_q[i] && voices_q[i].age != '1) begin
                        voices_q[i].age <= voices_q[i].age + AGE_W'(1);
                     end
                  end
                  key_on_q[tgt_d] <= !retrig_d;
                  tgt_q           <= tgt_d;
                  if (retrig_d) begin
                     state_q <= GAP;
                  end else begin
                     state_q    <= IDLE;
                     ev_ready_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end
               end else begin
                  // Note and amp stay put so the release tail keeps its pitch.
                  if (match_vld_q) key_on_q[match_idx_q] <= 1'b0;
                  state_q    <= IDLE;
                  ev_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            GAP: begin
               if (gap_done) begin
                  key_on_q[tgt_q] <= 1'b1;
                  state_q         <= IDLE;
                  ev_ready_q      <= 1'b1;
                  busy_q          <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      note_out = '0;
      amp_out  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         note_out[NOTE_W*i +: NOTE_W] = voices_q[i].note;
         amp_out[AMP_W*i +: AMP_W]    = voices_q[i].amp;
      end
   end

   assign key_on   = key_on_q;
   assign ev_ready = ev_ready_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed bench with a behavioural allocation model and per-cycle compare
`timescale 1ns/1ps
module tb_voice_allocator;
   localparam int NV = 4;
   localparam int G  = 2048;

   logic            Clk = 1'b0;
   logic            Reset = 1'b0;
   logic            ev_valid = 1'b0;
   logic            ev_on = 1'b0;
   logic [7:0]      ev_note = '0;
   logic [6:0]      ev_vel = '0;
   logic            ev_ready, busy;
   logic [NV-1:0]   key_on;
   logic [NV*8-1:0] note_out;
   logic [NV*16-1:0] amp_out;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   voice_allocator #(.NUM_VOICES(NV), .RETRIG_GAP(G)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_on   (ev_on),
      .ev_note (ev_note),
      .ev_vel  (ev_vel),
      .key_on  (key_on),
      .note_out(note_out),
      .amp_out (amp_out),
      .busy    (busy)
   );

   always #10 Clk = ~Clk;

   // Behavioural model: voice pool as plain arrays, event timeline in cycle counts.
   bit m_act [NV];
   int m_note [NV];
   int m_amp [NV];
   int m_age [NV];
   bit m_ready;
   int m_wait, m_gap, m_gtgt;
   bit e_on;
   int e_note, e_vel;

   task automatic m_clear();
      for (int i = 0; i < NV; i++) begin
         m_act[i] = 0; m_note[i] = 0; m_amp[i] = 0; m_age[i] = 0;
      end
      m_ready = 1; m_wait = 0; m_gap = 0; m_gtgt = 0;
   endtask

   task automatic m_apply();
      int  t;
      bit  need_gap;
      t = -1;
      need_gap = 1;
      for (int i = 0; i < NV; i++)
         if (t < 0 && m_act[i] && m_note[i] == e_note) t = i;
      if (!e_on) begin
         if (t >= 0) m_act[t] = 0;
         m_ready = 1;
         return;
      end
      for (int i = 0; i < NV; i++)
         if (t < 0 && !m_act[i]) begin t = i; need_gap = 0; end
      if (t < 0) begin
         t = 0;
         for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
      end
      for (int i = 0; i < NV; i++)
         if (i != t && m_act[i] && m_age[i] < 255) m_age[i]++;
      m_note[t] = e_note;
      m_amp[t]  = e_vel * 516 + e_vel / 32;
      m_age[t]  = 0;
      if (need_gap) begin
         m_act[t] = 0; m_gap = G; m_gtgt = t;
      end else begin
         m_act[t] = 1; m_ready = 1;
      end
   endtask

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_clear();
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) m_apply();
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) begin m_act[m_gtgt] = 1; m_ready = 1; end
      end else if (m_ready && ev_valid) begin
         e_on = ev_on && (ev_vel != 0);
         e_note = ev_note;
         e_vel = ev_vel;
         m_ready = 0;
         m_wait = NV + 1;
      end
   end

   logic [NV-1:0]    ek;
   logic [NV*8-1:0]  en;
   logic [NV*16-1:0] ea;

   always @(negedge Clk) begin
      if (cmp_en) begin
         for (int i = 0; i < NV; i++) begin
            ek[i] = m_act[i];
            en[8*i +: 8] = m_note[i][7:0];
            ea[16*i +: 16] = m_amp[i][15:0];
         end
         vectors++;
         if (key_on !== ek || note_out !== en || amp_out !== ea || ev_ready !== m_ready || busy !== !m_ready) begin
            miscompares++;
            $display("FAIL model_cycle @%0t: key_on=%b want %b note_out=%h want %h amp_out=%h want %h ev_ready=%b want %b busy=%b want %b",
                     $time, key_on, ek, note_out, en, amp_out, ea, ev_ready, m_ready, busy, !m_ready);
         end
      end
   end

   // Scoreboard of events offered versus handshakes seen on the pins.
   logic [15:0] sent_q [$];
   logic [15:0] acc_q [$];

   always @(negedge Clk)
      if (!Reset && ev_valid && ev_ready) acc_q.push_back({ev_on, ev_note, ev_vel});

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] ev, input bit hold);
      int n;
      if (!ev_valid) begin @(posedge Clk); #1; end
      {ev_on, ev_note, ev_vel} = ev;
      ev_valid = 1'b1;
      n = 0;
      @(negedge Clk);
      while (!ev_ready && n < 6000) begin @(negedge Clk); n++; end
      if (!ev_ready) chk("accept_timeout", 128'(ev_ready), 128'(1));
      @(posedge Clk); #1;
      sent_q.push_back(ev);
      if (!hold) begin
         ev_valid = 1'b0;
         ev_on = 1'($urandom);
         ev_note = 8'($urandom);
         ev_vel = 7'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge Clk);
      while (!ev_ready && n < 6000) begin @(negedge Clk); n++; end
      if (!ev_ready) chk("idle_timeout", 128'(ev_ready), 128'(1));
   endtask

   task automatic measure_gap(input int v, output int len);
      len = 0;
      while (key_on[v] === 1'b0 && len < 6000) begin len++; @(negedge Clk); end
   endtask

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] notes [4];
      int len;
      notes = '{8'd60, 8'd64, 8'd67, 8'd72};

      #5 Reset = 1'b1;
      @(negedge Clk);
      chk("reset_outputs", {key_on, note_out, amp_out, ev_ready, busy}, {4'b0, 32'b0, 64'b0, 1'b1, 1'b0});
      cmp_en = 1'b1;
      Reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         send({1'b1, notes[i], 7'd127}, 1'b0);
         repeat (4) @(posedge Clk);
         @(negedge Clk);
         chk("apply_not_before_T6", {key_on[i], ev_ready, busy}, {1'b0, 1'b0, 1'b1});
         @(posedge Clk);
         @(negedge Clk);
         chk("update_at_T6", {key_on[i], note_out[8*i +: 8], amp_out[16*i +: 16], ev_ready},
             {1'b1, notes[i], 16'hFFFF, 1'b1});
      end
      chk("four_key_on", 128'(key_on), 128'(4'hF));
      chk("four_notes", 128'(note_out), 128'(32'h48_43_40_3C));
      chk("four_amps", 128'(amp_out), 128'(64'hFFFF_FFFF_FFFF_FFFF));

      send({1'b1, 8'd76, 7'd64}, 1'b0);
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      chk("steal_voice0", {key_on, note_out[7:0], amp_out[15:0]}, {4'b1110, 8'd76, 16'h8102});
      measure_gap(0, len);
      chk("steal_gap_len", 128'(len), 128'(G));
      chk("steal_ready_with_rise", {key_on, ev_ready}, {4'b1111, 1'b1});

      send({1'b0, 8'd64, 7'd33}, 1'b0);
      wait_idle();
      chk("off64_key", 128'(key_on), 128'(4'b1101));
      chk("off64_note_kept", 128'(note_out[15:8]), 128'(8'd64));

      send({1'b1, 8'd79, 7'd100}, 1'b0);
      wait_idle();
      chk("on79_voice1", {key_on, note_out[15:8], amp_out[31:16]}, {4'hF, 8'd79, 16'hC993});

      send({1'b0, 8'd50, 7'd10}, 1'b0);
      repeat (4) @(posedge Clk);
      @(negedge Clk);
      chk("off50_ready_low_T5", 128'(ev_ready), 128'(0));
      @(posedge Clk);
      @(negedge Clk);
      chk("off50_ready_T6", 128'(ev_ready), 128'(1));
      chk("off50_no_change", {key_on, note_out, amp_out}, {4'hF, 32'h48434F4C, 64'hFFFF_FFFF_C993_8102});

      send({1'b1, 8'd67, 7'd0}, 1'b0);
      wait_idle();
      chk("vel0_is_off", 128'(key_on), 128'(4'b1011));
      chk("vel0_note_kept", 128'(note_out), 128'(32'h48434F4C));

      send({1'b1, 8'd72, 7'd127}, 1'b0);
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      chk("retrig_start", {key_on, note_out, amp_out}, {4'b0011, 32'h48434F4C, 64'hFFFF_FFFF_C993_8102});
      measure_gap(3, len);
      chk("retrig_gap_len", 128'(len), 128'(G));
      chk("retrig_end", {key_on, ev_ready}, {4'b1011, 1'b1});

      send({1'b1, 8'd76, 7'd64}, 1'b0);
      repeat (105) @(posedge Clk);
      #1;
      chk("mid_gap_key_on", {key_on, busy}, {4'b1010, 1'b1});
      #3 Reset = 1'b1;
      #1;
      chk("reset_in_gap", {key_on, note_out, amp_out, ev_ready, busy}, {4'b0, 32'b0, 64'b0, 1'b1, 1'b0});
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      chk("after_reset_idle", {key_on, ev_ready, busy}, {4'b0, 1'b1, 1'b0});

      send({1'b1, 8'd60, 7'd127}, 1'b1);
      send({1'b1, 8'd62, 7'd90}, 1'b1);
      send({1'b0, 8'd60, 7'd5}, 1'b1);
      send({1'b1, 8'd62, 7'd50}, 1'b1);
      send({1'b1, 8'd65, 7'd10}, 1'b1);
      send({1'b0, 8'd99, 7'd7}, 1'b1);
      send({1'b1, 8'd70, 7'd1}, 1'b0);
      wait_idle();
      chk("stream_key_on", 128'(key_on), 128'(4'b0111));
      chk("stream_notes", 128'(note_out), 128'(32'h00463E41));
      chk("stream_amps", 128'(amp_out), 128'(64'h0000_0204_64C9_1428));

      chk("sb_sent_total", 128'(sent_q.size()), 128'(18));
      chk("sb_accept_count", 128'(acc_q.size()), 128'(sent_q.size()));
      for (int i = 0; i < sent_q.size() && i < acc_q.size(); i++)
         chk($sformatf("sb_event_%0d", i), 128'(acc_q[i]), 128'(sent_q[i]));

      repeat (2) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
